// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the UART store-and-forward bridge.
package uart_bridge_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Returns the bit that completes the requested parity over the low nbits.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input int unsigned nbits,
                                        input int unsigned mode);
        logic p;
        p = (mode == PAR_ODD);
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) p ^= data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_bridge_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is honoured only
// when a pop frees a slot in the same cycle.
module uart_bridge_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// UART-to-UART store-and-forward bridge: RX deframer -> FIFO -> TX framer,
// with CTS/RTS flow control and sticky error status.
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned RTS_MARGIN   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    input  logic                          cts_i,
    input  logic                          clr_err_i,
    output logic                          tx_o,
    output logic                          rts_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] STOP_CNT = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam bit            HAS_PAR  = (PARITY != PAR_NONE);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_par_q, rx_par_d;
    logic            wr_q, wr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            frame_ev, parity_ev, overflow_ev;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic            tx_par_q, tx_par_d;
    logic            tx_q, tx_d;
    logic            pop, start_ok;

    logic            ovf_q, fe_q, pe_q, rts_q;
    logic [7:0]      fifo_dout;
    logic            fifo_empty, fifo_full;
    logic [LW-1:0]   fifo_level;

    uart_bridge_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_q),
        .pop_i   (pop),
        .din_i   (wr_data_q),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_par_d   = rx_par_q;
        wr_d       = 1'b0;
        wr_data_d  = wr_data_q;
        frame_ev   = 1'b0;
        parity_ev  = 1'b0;
        if (rx_state_q != RX_IDLE && rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CW'(1);
        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_CNT;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (sync2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_CNT;
                        rx_bit_d   = '0;
                        rx_data_d  = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_data_d[rx_bit_q] = sync2_q;
                    rx_cnt_d            = BIT_CNT;
                    if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == '0) begin
                    rx_par_d   = sync2_q;
                    rx_state_d = RX_STOP;
                    rx_cnt_d   = BIT_CNT;
                end
            end
            RX_STOP: begin
                // Back to IDLE at the stop mid-point so a new start edge is caught at once.
                if (rx_cnt_q == '0) begin
                    frame_ev   = !sync2_q;
                    parity_ev  = HAS_PAR &&
                                 (rx_par_q != parity_bit(rx_data_q, DATA_BITS, PARITY));
                    wr_d       = !frame_ev && !parity_ev;
                    wr_data_d  = rx_data_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign start_ok    = !fifo_empty && cts_i;
    assign overflow_ev = wr_q && fifo_full && !pop;

    // tx_d is the line level for the state being entered, keeping tx_o registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        if (tx_state_q != TX_IDLE && tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CW'(1);
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    pop        = 1'b1;
                    tx_sh_d    = fifo_dout;
                    tx_par_d   = parity_bit(fifo_dout, DATA_BITS, PARITY);
                    tx_state_d = TX_START;
                    tx_cnt_d   = BIT_CNT;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_CNT;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_CNT;
                    if (tx_bit_q == LAST_BIT) begin
                        if (HAS_PAR) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_cnt_d   = STOP_CNT;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_d     = tx_sh_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = STOP_CNT;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (start_ok) begin
                        pop        = 1'b1;
                        tx_sh_d    = fifo_dout;
                        tx_par_d   = parity_bit(fifo_dout, DATA_BITS, PARITY);
                        tx_state_d = TX_START;
                        tx_cnt_d   = BIT_CNT;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
            wr_q       <= 1'b0;
            wr_data_q  <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            rts_q      <= 1'b1;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_par_q   <= rx_par_d;
            wr_q       <= wr_d;
            wr_data_q  <= wr_data_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            ovf_q      <= (ovf_q && !clr_err_i) || overflow_ev;
            fe_q       <= (fe_q  && !clr_err_i) || frame_ev;
            pe_q       <= (pe_q  && !clr_err_i) || parity_ev;
            rts_q      <= (fifo_level < LW'(FIFO_DEPTH - RTS_MARGIN));
        end
    end

    assign tx_o         = tx_q;
    assign rts_o        = rts_q;
    assign fifo_level_o = fifo_level;
    assign overflow_o   = ovf_q;
    assign frame_err_o  = fe_q;
    assign parity_err_o = pe_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench: two bridges (no parity / even parity), serial frames driven
// on rx, TX frames decoded by monitors and checked against queued expectations.
module tb_uart_fifo_bridge;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1, cts0 = 1'b1, cts1 = 1'b1, clr0 = 1'b0, clr1 = 1'b0;
    logic tx0, tx1, rts0, rts1, ovf0, ovf1, fe0, fe1, pe0, pe1;
    logic [2:0] lvl0, lvl1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lvl_hits = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic fm[2], pm[2], om[2];
    logic ign0 = 1'b0;
    logic b2b0 = 1'b0;
    int b2b_cnt = 0;
    int last_start = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lvl0 != 3'd0) lvl_hits <= lvl_hits + 1;
    end

    uart_fifo_bridge #(
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4), .RTS_MARGIN(1)
    ) dut0 (
        .clk(clk), .rst(rst), .rx_i(rx0), .cts_i(cts0), .clr_err_i(clr0),
        .tx_o(tx0), .rts_o(rts0), .fifo_level_o(lvl0),
        .overflow_o(ovf0), .frame_err_o(fe0), .parity_err_o(pe0)
    );

    uart_fifo_bridge #(
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4), .RTS_MARGIN(1)
    ) dut1 (
        .clk(clk), .rst(rst), .rx_i(rx1), .cts_i(cts1), .clr_err_i(clr1),
        .tx_o(tx1), .rts_o(rts1), .fifo_level_o(lvl1),
        .overflow_o(ovf1), .frame_err_o(fe1), .parity_err_o(pe1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic txw(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic push_exp(input int k, input logic [7:0] d);
        if (k == 0) exp0.push_back(d);
        else        exp1.push_back(d);
    endtask

    task automatic set_rx(input int k, input logic v);
        if (k == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic bit_out(input int k, input logic v);
        set_rx(k, v);
        repeat (CPB) begin @(posedge clk); #1; end
    endtask

    task automatic send_char(input int k, input logic [7:0] d, input logic pbit,
                             input logic stop, input int idle);
        @(posedge clk); #1;
        bit_out(k, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(k, d[i]);
        if (k == 1) bit_out(k, pbit);
        bit_out(k, stop);
        set_rx(k, 1'b1);
        repeat (idle * CPB) begin @(posedge clk); #1; end
    endtask

    task automatic chk_flags(input int k);
        @(negedge clk);
        check("frame_err", (k == 0) ? fe0 : fe1, fm[k]);
        check("parity_err", (k == 0) ? pe0 : pe1, pm[k]);
        check("overflow", (k == 0) ? ovf0 : ovf1, om[k]);
    endtask

    task automatic pulse_clr(input int k);
        @(posedge clk); #1;
        if (k == 0) clr0 = 1'b1; else clr1 = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0; clr1 = 1'b0;
        fm[k] = 1'b0; pm[k] = 1'b0; om[k] = 1'b0;
        chk_flags(k);
    endtask

    task automatic drain(input int k, input int budget);
        int n = 0;
        while (qsize(k) != 0 && n < budget) begin @(negedge clk); n++; end
        check("drain_timeout", qsize(k), 0);
    endtask

    task automatic monitor(input int k);
        logic [7:0] d;
        logic [7:0] e;
        logic pb, st, s0;
        int sc;
        forever begin
            @(negedge clk);
            if (txw(k) == 1'b0) begin
                sc = cyc;
                pb = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                s0 = txw(k);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = txw(k);
                end
                if (k == 1) begin
                    repeat (CPB) @(negedge clk);
                    pb = txw(k);
                end
                repeat (CPB) @(negedge clk);
                st = txw(k);
                if (k == 0 && ign0) begin
                    ign0 = 1'b0;
                end else begin
                    check("tx_start_bit", s0, 1'b0);
                    check("tx_stop_bit", st, 1'b1);
                    if (k == 1) check("tx_parity_bit", pb, ^d);
                    if (qsize(k) == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL tx_unexpected_frame dut%0d: got data %02h, expected no frame", k, d);
                    end else begin
                        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                        check("tx_data", d, e);
                    end
                    if (k == 0 && b2b0) begin
                        if (b2b_cnt > 0) check("tx_b2b_gap", sc - last_start, 10 * CPB);
                        b2b_cnt++;
                        last_start = sc;
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [7:0] ovf_data [5];
        logic bad_stop, bad_par;
        int h, n;

        for (int k = 0; k < 2; k++) begin fm[k] = 0; pm[k] = 0; om[k] = 0; end
        ovf_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx0", tx0, 1'b1);
        check("rst_rts0", rts0, 1'b1);
        check("rst_lvl0", lvl0, 0);
        check("rst_tx1", tx1, 1'b1);
        check("rst_rts1", rts1, 1'b1);
        check("rst_lvl1", lvl1, 0);
        chk_flags(0);
        chk_flags(1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Echo 0xA5, level pulses 1 for one cycle
        h = lvl_hits;
        push_exp(0, 8'hA5);
        send_char(0, 8'hA5, 1'b0, 1'b1, 2);
        drain(0, 400);
        check("echo_level_pulse", lvl_hits - h, 1);
        chk_flags(0);

        // Parity: bad parity dropped, good parity echoed
        send_char(1, 8'h03, 1'b1, 1'b1, 2);
        pm[1] = 1'b1;
        chk_flags(1);
        push_exp(1, 8'h03);
        send_char(1, 8'h03, 1'b0, 1'b1, 2);
        drain(1, 400);
        chk_flags(1);
        pulse_clr(1);

        // Framing error
        send_char(0, 8'h55, 1'b0, 1'b0, 2);
        fm[0] = 1'b1;
        chk_flags(0);
        pulse_clr(0);

        // Glitch: one-cycle low pulse
        @(posedge clk); #1; rx0 = 1'b0;
        @(posedge clk); #1; rx0 = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_lvl", lvl0, 0);
        chk_flags(0);
        push_exp(0, 8'hC3);
        send_char(0, 8'hC3, 1'b0, 1'b1, 2);
        drain(0, 400);

        // Flow control and overflow
        @(posedge clk); #1; cts0 = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(0, ovf_data[i]);
        for (int i = 0; i < 5; i++) begin
            send_char(0, ovf_data[i], 1'b0, 1'b1, 2);
            @(negedge clk);
            check("fc_level", lvl0, (i < 4) ? i + 1 : 4);
            check("fc_rts", rts0, (i < 2) ? 1 : 0);
        end
        om[0] = 1'b1;
        chk_flags(0);
        b2b_cnt = 0;
        b2b0 = 1'b1;
        @(posedge clk); #1; cts0 = 1'b1;
        drain(0, 600);
        b2b0 = 1'b0;
        check("b2b_frames", b2b_cnt, 4);
        repeat (3) @(negedge clk);
        check("fc_level_empty", lvl0, 0);
        check("fc_rts_back", rts0, 1'b1);
        pulse_clr(0);

        // Randomized traffic on both bridges
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                d = 8'($urandom);
                bad_stop = ($urandom_range(0, 7) == 0);
                bad_par = (k == 1) && ($urandom_range(0, 5) == 0);
                if (!bad_stop && !bad_par) push_exp(k, d);
                send_char(k, d, (^d) ^ bad_par, !bad_stop, 2);
                if (bad_stop) fm[k] = 1'b1;
                if (bad_par) pm[k] = 1'b1;
                chk_flags(k);
                if ($urandom_range(0, 3) == 0) pulse_clr(k);
            end
            drain(k, 800);
        end

        // Reset during TX data bit 3
        ign0 = 1'b1;
        send_char(0, 8'h3C, 1'b0, 1'b1, 0);
        n = 0;
        while (tx0 !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("rst_tx_start_seen", tx0, 1'b0);
        repeat (4 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin fm[k] = 0; pm[k] = 0; om[k] = 0; end
        check("midrst_tx", tx0, 1'b1);
        check("midrst_lvl", lvl0, 0);
        check("midrst_rts", rts0, 1'b1);
        check("midrst_fe", fe0, 1'b0);
        check("midrst_pe", pe0, 1'b0);
        check("midrst_ovf", ovf0, 1'b0);
        repeat (10) @(negedge clk);
        push_exp(0, 8'h5A);
        send_char(0, 8'h5A, 1'b0, 1'b1, 2);
        drain(0, 400);
        chk_flags(0);
        chk_flags(1);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
